// File: rtl/sram_banked_if.sv
// sram_banked_if
//   Request/response bus of the banked SRAM.
//   Request : req_valid/req_ready handshake carrying req_we, req_addr, req_wdata
//             and req_wmask (byte enables, bit i -> byte i).
//   Response: rsp_valid pulses once per read with rsp_rdata; there is no
//             response backpressure.
//   Status  : init_done goes high once the post-reset clear has finished.
//   master = requester side, slave = the memory.
interface sram_banked_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 64
) ();
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_we;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic [DATA_WIDTH/8-1:0] req_wmask;
   logic                    rsp_valid;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic                    init_done;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wmask,
      input  req_ready, rsp_valid, rsp_rdata, init_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wmask,
      output req_ready, rsp_valid, rsp_rdata, init_done
   );
endinterface

// File: rtl/sram_banked.sv
// sram_banked
//   Word-addressed on-chip SRAM split into NUM_BANKS interleaved banks
//   (bank = low address bits, row = remaining bits). One request per cycle,
//   byte-masked writes, reads return after READ_LATENCY (1 or 2) cycles.
//   After reset a clear engine writes zero to one row of every bank per cycle;
//   requests are held off (req_ready=0) until it finishes.
// Ports
//   clk  : clock
//   rst  : synchronous reset, active high (does not touch array contents)
//   bus  : sram_banked_if.slave -- request handshake, read response, init_done

// One bank: synchronous byte-masked write, synchronous registered read.
// The read register holds its value until the next read of this bank.
module sram_banked_bank #(
   parameter int ROW_W      = 13,
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic                    re,
   input  logic [ROW_W-1:0]        row,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wmask,
   output logic [DATA_WIDTH-1:0]   rdata
);
   localparam int NBYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [0:(1<<ROW_W)-1];
   logic [DATA_WIDTH-1:0] rd_q, rd_d;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (wmask[b]) mem[row][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // Read sees the word as it was at the accept edge (write and read are
   // never issued to the same bank in the same cycle).
   always_comb begin
      rd_d = rd_q;
      if (re) rd_d = mem[row];
   end

   always_ff @(posedge clk) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_d;
   end

   assign rdata = rd_q;
endmodule

module sram_banked #(
   parameter int ADDR_WIDTH     = 15,
   parameter int DATA_WIDTH     = 64,
   parameter int NUM_BANKS      = 4,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic         clk,
   input  logic         rst,
   sram_banked_if.slave bus
);
   localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
   localparam int SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
   localparam int ROW_W     = ADDR_WIDTH - BANK_BITS;
   localparam int NBYTES    = DATA_WIDTH / 8;

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_lat
      $error("sram_banked: READ_LATENCY must be 1 or 2");
   end
   if (NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_chk_banks
      $error("sram_banked: NUM_BANKS must be a power of 2");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_chk_width
      $error("sram_banked: DATA_WIDTH must be a multiple of 8");
   end

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t                  state_q, state_d;
   logic [ROW_W-1:0]        clr_cnt_q, clr_cnt_d;
   logic                    ready_q, ready_d;
   logic                    done_q, done_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;

   logic             accept, rd_acc, wr_acc, clearing;
   logic [SEL_W-1:0] req_bank;
   logic [ROW_W-1:0] req_row;

   logic [NUM_BANKS-1:0]                 bank_we, bank_re;
   logic [ROW_W-1:0]                     bank_row;
   logic [DATA_WIDTH-1:0]                bank_wdata;
   logic [NBYTES-1:0]                    bank_wmask;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rd;
   logic [DATA_WIDTH-1:0]                rd_mux;

   // Nothing is accepted or written on a reset edge, so rst alone never
   // changes array contents.
   assign accept   = bus.req_valid & ready_q & ~rst;
   assign rd_acc   = accept & ~bus.req_we;
   assign wr_acc   = accept &  bus.req_we;
   assign clearing = (state_q == S_CLEAR) & ~rst;
   assign req_bank = (NUM_BANKS > 1) ? bus.req_addr[SEL_W-1:0] : '0;
   assign req_row  = ROW_W'(bus.req_addr >> BANK_BITS);

   // The clear engine owns the shared write port of every bank while it runs;
   // requests cannot collide with it because req_ready is low in S_CLEAR.
   always_comb begin
      bank_row   = clearing ? clr_cnt_q : req_row;
      bank_wdata = clearing ? '0 : bus.req_wdata;
      bank_wmask = clearing ? '1 : bus.req_wmask;
      bank_we    = '0;
      bank_re    = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_we[b] = clearing | (wr_acc & (req_bank == SEL_W'(b)));
         bank_re[b] = rd_acc & (req_bank == SEL_W'(b));
      end
   end

   sram_banked_bank #(
      .ROW_W      (ROW_W),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_bank [NUM_BANKS-1:0] (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we),
      .re    (bank_re),
      .row   (bank_row),
      .wdata (bank_wdata),
      .wmask (bank_wmask),
      .rdata (bank_rd)
   );

   // sel_q and the bank read registers only move on a read accept, so the
   // muxed word holds steady until the next read.
   assign rd_mux = bank_rd[sel_q];

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      ready_d    = ready_q;
      done_d     = done_q;
      sel_d      = rd_acc ? req_bank : sel_q;
      vld_pipe_d = READ_LATENCY'({vld_pipe_q, rd_acc});
      case (state_q)
         S_CLEAR: begin
            ready_d   = 1'b0;
            done_d    = 1'b0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
               state_d = S_RUN;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end
         end
         S_RUN: begin
            ready_d = 1'b1;
            done_d  = 1'b1;
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
         clr_cnt_q  <= '0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
         sel_q      <= '0;
         vld_pipe_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         sel_q      <= sel_d;
         vld_pipe_q <= vld_pipe_d;
      end
   end

   // Second latency stage captures the muxed word one edge after the bank read.
   if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rd2_q, rd2_d;

      always_comb begin
         rd2_d = rd2_q;
         if (vld_pipe_q[0]) rd2_d = rd_mux;
      end

      always_ff @(posedge clk) begin
         if (rst) rd2_q <= '0;
         else     rd2_q <= rd2_d;
      end

      assign bus.rsp_rdata = rd2_q;
   end else begin : g_lat1
      assign bus.rsp_rdata = rd_mux;
   end

   assign bus.rsp_valid = vld_pipe_q[READ_LATENCY-1];
   assign bus.req_ready = ready_q;
   assign bus.init_done = done_q;
endmodule

// File: tb/tb_sram_banked.sv
// Testbench for sram_banked. Two instances (READ_LATENCY 1 and 2) receive the
// same request stream. A word-level reference model (associative array, byte
// merge) predicts read data; expected responses are queued per instance with
// the cycle they are due and a monitor pops and checks them.
module tb_sram_banked;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [14:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_wmask = '0;

   always #5 clk = ~clk;

   sram_banked_if #(.ADDR_WIDTH(15), .DATA_WIDTH(64)) b1 ();
   sram_banked_if #(.ADDR_WIDTH(15), .DATA_WIDTH(64)) b2 ();

   assign b1.req_valid = req_valid;
   assign b1.req_we    = req_we;
   assign b1.req_addr  = req_addr;
   assign b1.req_wdata = req_wdata;
   assign b1.req_wmask = req_wmask;
   assign b2.req_valid = req_valid;
   assign b2.req_we    = req_we;
   assign b2.req_addr  = req_addr;
   assign b2.req_wdata = req_wdata;
   assign b2.req_wmask = req_wmask;

   sram_banked #(.READ_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
   sram_banked #(.READ_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   int rst_cyc = 0;

   typedef struct {
      logic [63:0] data;
      int          due;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   logic [63:0] model [int];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_rd(input int a);
      return model.exists(a) ? model[a] : 64'h0;
   endfunction

   function automatic void ref_wr(input int a, input logic [63:0] d, input logic [7:0] m);
      logic [63:0] w;
      w = ref_rd(a);
      for (int i = 0; i < 8; i++) if (m[i]) w[i*8 +: 8] = d[i*8 +: 8];
      model[a] = w;
   endfunction

   // Called at a negedge. Holds the request until both instances show ready,
   // returns at the negedge after the accept edge with t = accept edge number.
   task automatic do_req(input bit we, input int addr, input logic [63:0] d,
                         input logic [7:0] m, output int t);
      int   n;
      exp_t e;
      n = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr[14:0];
      req_wdata = d;
      req_wmask = m;
      while (!(b1.req_ready && b2.req_ready)) begin
         @(negedge clk);
         n++;
         if (n > 20000) begin
            $display("FAIL req_wait: req_ready still 0 after %0d cycles, expected 1", n);
            $fatal(1, "request never accepted");
         end
      end
      t = cyc + 1;
      if (we) ref_wr(addr, d, m);
      else begin
         e.data = ref_rd(addr);
         e.due  = t;
         q1.push_back(e);
         e.due  = t + 1;
         q2.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Reads still in flight at the reset edge must never respond.
   task automatic do_reset();
      req_valid = 1'b0;
      rst = 1'b1;
      q1.delete();
      q2.delete();
      @(negedge clk);
      chk("rst_ready1", b1.req_ready, 0);
      chk("rst_valid1", b1.rsp_valid, 0);
      chk("rst_rdata1", b1.rsp_rdata, 0);
      chk("rst_done1",  b1.init_done, 0);
      chk("rst_ready2", b2.req_ready, 0);
      chk("rst_valid2", b2.rsp_valid, 0);
      chk("rst_rdata2", b2.rsp_rdata, 0);
      chk("rst_done2",  b2.init_done, 0);
      rst = 1'b0;
      rst_cyc = cyc;
      model.delete();
   endtask

   task automatic wait_init();
      int n;
      n = 0;
      while (!(b1.init_done && b2.init_done) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("clear_cycles", 64'(cyc - rst_cyc), 64'd8192);
      chk("ready_after_clear1", b1.req_ready, 1);
      chk("ready_after_clear2", b2.req_ready, 1);
   endtask

   task automatic mon(input int k, input logic v, input logic [63:0] d);
      exp_t e;
      bit   have;
      have = (k == 1) ? (q1.size() > 0) : (q2.size() > 0);
      if (have) e = (k == 1) ? q1[0] : q2[0];
      if (v === 1'b1) begin
         if (!have) begin
            total++;
            bad++;
            $display("FAIL rsp%0d_unexpected: rsp_valid=1 at cycle %0d, expected no response", k, cyc);
         end else begin
            if (k == 1) void'(q1.pop_front()); else void'(q2.pop_front());
            chk($sformatf("rsp%0d_data", k), d, e.data);
            chk($sformatf("rsp%0d_cycle", k), 64'(cyc), 64'(e.due));
         end
      end else if (have && e.due <= cyc) begin
         if (k == 1) void'(q1.pop_front()); else void'(q2.pop_front());
         total++;
         bad++;
         $display("FAIL rsp%0d_missing: rsp_valid=0 at cycle %0d, expected response due at %0d", k, cyc, e.due);
      end
   endtask

   always @(posedge clk) begin
      #1;
      mon(1, b1.rsp_valid, b1.rsp_rdata);
      mon(2, b2.rsp_valid, b2.rsp_rdata);
   end

   initial begin
      #(100000 * 10);
      $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          t;
      int          a;
      logic [63:0] d;

      // Clear after reset, then the far corner reads back as zero.
      do_reset();
      wait_init();
      do_req(0, 'h7FFF, '0, '0, t);

      // Masked overwrite of the low half.
      do_req(1, 'h5, 64'h1122334455667788, 8'hFF, t);
      do_req(1, 'h5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, t);
      do_req(0, 'h5, '0, '0, t);
      idle(1);
      chk("masked_model", ref_rd('h5), 64'h11223344AAAAAAAA);
      // All-zero mask is a no-op.
      do_req(1, 'h5, 64'hFFFFFFFFFFFFFFFF, 8'h00, t);
      do_req(0, 'h5, '0, '0, t);
      idle(2);

      // Back-to-back reads in order.
      for (int i = 0; i < 3; i++) do_req(1, 'h10 + i, 64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF, t);
      idle(1);
      for (int i = 0; i < 3; i++) do_req(0, 'h10 + i, '0, '0, t);
      idle(3);

      // Neighbouring addresses land in different banks without aliasing.
      for (int i = 0; i < 8; i++) do_req(1, i, 64'(i * 'h0101), 8'hFF, t);
      for (int i = 0; i < 8; i++) do_req(0, i, '0, '0, t);
      idle(2);

      // Write immediately followed by a read of the same word.
      do_req(1, 'h123, 64'h0123456789ABCDEF, 8'hFF, t);
      do_req(0, 'h123, '0, '0, t);
      idle(2);

      // Random traffic, mostly on a small address window to get reuse.
      repeat (400) begin
         a = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 32767));
         d = {$urandom, $urandom};
         do_req(bit'($urandom_range(0, 1)), a, d, 8'($urandom), t);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(5);
      chk("drain_a", 64'(q1.size() + q2.size()), 64'd0);

      // Reset part-way through the clear restarts it from row 0.
      do_reset();
      idle(100);
      do_reset();
      wait_init();

      // Reset with a read in flight on the 2-cycle instance drops it.
      do_req(1, 'h40, 64'hDEADBEEFDEADBEEF, 8'hFF, t);
      do_req(0, 'h40, '0, '0, t);
      do_reset();

      // Write held through the clear is accepted on the first ready cycle.
      do_req(1, 'h77, 64'h8877665544332211, 8'h3C, t);
      chk("stall_accept_cycle", 64'(t - rst_cyc), 64'd8193);
      do_req(0, 'h77, '0, '0, t);
      do_req(0, 'h40, '0, '0, t);
      idle(5);
      chk("drain_b", 64'(q1.size() + q2.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
